crc_stream_engine: RTL and testbench

Sequential, parametrised CRC engine for the SPI execution unit. It accumulates a CRC over a multi-word message streamed in on a valid/ready handshake. Each word is processed CHUNK bits per clock, MSB first, and the polynomial and initial value are set at runtime. It has two modes: generate (output the CRC remainder) and check (test the message plus its appended CRC for a zero residue). The block sits between the SPI shift datapath and the status/control logic, and replaces single-shot combinational CRC evaluation.

---
 rtl/crc_pkg.sv | 17 +
 rtl/crc_chunk_step.sv | 32 +++
 rtl/crc_stream_engine.sv | 123 ++++++++++++
 tb/tb_crc_stream_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types for the streaming CRC engine: FSM states and the per-message mode.
package crc_pkg;

  localparam int CRC_MODE_W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [CRC_MODE_W-1:0] {
    CRC_GEN   = 1'b0,
    CRC_CHECK = 1'b1
  } mode_t;

endpackage

// File: rtl/crc_chunk_step.sv
// Combinational CHUNK-bit CRC advance: MSB-first, unreflected, no final XOR.
module crc_chunk_step #(
  parameter int WPOLY = 9,
  parameter int CHUNK = 4
) (
  input  logic [WPOLY-2:0] s,
  input  logic [CHUNK-1:0] chunk,
  input  logic [WPOLY-1:0] poly,
  output logic [WPOLY-2:0] s_next
);

  localparam int WCRC = WPOLY - 1;

  logic [WCRC-1:0] acc;
  logic            fb;
  logic            unused_lead;

  // The leading 1 of the polynomial is implied by the shift-out of the top bit.
  assign unused_lead = poly[WPOLY-1];

  always_comb begin
    acc = s;
    fb  = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      fb  = acc[WCRC-1] ^ chunk[i];
      acc = {acc[WCRC-2:0], 1'b0};
      if (fb) acc = acc ^ poly[WCRC-1:0];
    end
    s_next = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Multi-word streaming CRC engine: accepts one word per handshake, folds it in
// CHUNK bits per clock, and presents the generate/check result on a held valid.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int WDATA = 8,
  parameter int WPOLY = 9,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_init,
  input  logic             i_mode,
  input  logic             i_valid,
  input  logic [WDATA-1:0] i_data,
  input  logic             i_first,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_match
);

  localparam int WCRC  = WPOLY - 1;
  localparam int N     = WDATA / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WDATA % CHUNK != 0) begin : g_bad_chunk
      $error("crc_stream_engine: WDATA must be a multiple of CHUNK");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WCRC-1:0]    s_q, s_next;
  logic [WPOLY-1:0]   poly_q;
  mode_t              mode_q;
  logic [WDATA-1:0]   data_q;
  logic               last_q;
  logic               msg_open_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WCRC-1:0]    crc_q;
  logic               match_q;

  crc_chunk_step #(
    .WPOLY (WPOLY),
    .CHUNK (CHUNK)
  ) u_step (
    .s      (s_q),
    .chunk  (data_q[WDATA-1 -: CHUNK]),
    .poly   (poly_q),
    .s_next (s_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = last_q ? DONE : IDLE;
      DONE:    if (i_res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (state_q == IDLE);
    o_res_valid = (state_q == DONE);
  end

  // Result is captured from the final step so it is stable for the whole DONE wait.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_q        <= '0;
      poly_q     <= '0;
      mode_q     <= CRC_GEN;
      data_q     <= '0;
      last_q     <= 1'b0;
      msg_open_q <= 1'b0;
      cnt_q      <= '0;
      crc_q      <= '0;
      match_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            data_q <= i_data;
            last_q <= i_last;
            cnt_q  <= CNT_W'(N - 1);
            if (i_first || !msg_open_q) begin
              s_q        <= i_init;
              poly_q     <= i_poly;
              mode_q     <= mode_t'(i_mode);
              msg_open_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          s_q    <= s_next;
          data_q <= data_q << CHUNK;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (last_q) begin
            msg_open_q <= 1'b0;
            crc_q      <= s_next;
            match_q    <= (mode_q == CRC_CHECK) && (s_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_crc   = crc_q;
  assign o_match = match_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench: an 8-bit/CHUNK=4 CRC-8 engine and a 16-bit/CHUNK=1 CRC-16 engine.
module tb_crc_stream_engine;

  typedef struct {
    logic [15:0] crc;
    logic        match;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid8, valid16;
  logic [7:0]  data_s;
  logic        first_s, last_s, mode_s, res_ready;
  logic [8:0]  poly8;
  logic [7:0]  init8;
  logic [16:0] poly16;
  logic [15:0] init16;
  logic        rdy8, rv8, match8, rdy16, rv16, match16;
  logic [7:0]  crc8;
  logic [15:0] crc16;

  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q16[$];
  logic [7:0] msg[$];
  logic [7:0] base[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  always #5 clk = ~clk;

  crc_stream_engine #(.WDATA(8), .WPOLY(9), .CHUNK(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_poly(poly8), .i_init(init8), .i_mode(mode_s),
    .i_valid(valid8), .i_data(data_s), .i_first(first_s), .i_last(last_s),
    .o_ready(rdy8), .o_res_valid(rv8), .i_res_ready(res_ready),
    .o_crc(crc8), .o_match(match8)
  );

  crc_stream_engine #(.WDATA(8), .WPOLY(17), .CHUNK(1)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_poly(poly16), .i_init(init16), .i_mode(mode_s),
    .i_valid(valid16), .i_data(data_s), .i_first(first_s), .i_last(last_s),
    .o_ready(rdy16), .o_res_valid(rv16), .i_res_ready(res_ready),
    .o_crc(crc16), .o_match(match16)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors pop the scoreboard whenever a result is accepted.
  always @(negedge clk) begin
    if (rv8 === 1'b1 && res_ready === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected8: got crc 0x%0h, expected no result", crc8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        checkOutput("crc8", 32'(crc8), 32'(e.crc[7:0]));
        checkOutput("match8", 32'(match8), 32'(e.match));
      end
    end
  end

  always @(negedge clk) begin
    if (rv16 === 1'b1 && res_ready === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected16: got crc 0x%0h, expected no result", crc16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        checkOutput("crc16", 32'(crc16), 32'(e.crc));
        checkOutput("match16", 32'(match16), 32'(e.match));
      end
    end
  end

  function automatic bit doneCond(input int sel, input bit last);
    if (sel == 0) return last ? (rv8 === 1'b1) : (rdy8 === 1'b1);
    return last ? (rv16 === 1'b1) : (rdy16 === 1'b1);
  endfunction

  task automatic pushExp(input int sel, input logic [15:0] crc, input logic match);
    exp_t e;
    e.crc = crc; e.match = match;
    if (sel == 0) q8.push_back(e);
    else          q16.push_back(e);
  endtask

  task automatic handshake(input int sel, input logic [7:0] d, input bit first, input bit last);
    int w;
    @(posedge clk); #1;
    data_s = d; first_s = first; last_s = last;
    if (sel == 0) valid8 = 1'b1; else valid16 = 1'b1;
    w = 0;
    @(negedge clk);
    while (!doneCond(sel, 1'b0) && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!doneCond(sel, 1'b0)) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout: got ready 0, expected 1");
    end
    @(posedge clk); #1;
    valid8 = 1'b0; valid16 = 1'b0;
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] d, input bit first, input bit last,
                               input bit hold, output int cyc);
    handshake(sel, d, first, last);
    if (hold) begin
      data_s = 8'hFF; first_s = 1'b1; last_s = 1'b0;
      if (sel == 0) valid8 = 1'b1; else valid16 = 1'b1;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!doneCond(sel, last) && cyc < 40);
    valid8 = 1'b0; valid16 = 1'b0;
    if (!doneCond(sel, last)) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout: got no completion, expected one within 40 cycles");
    end
  endtask

  task automatic sendMsg(input int sel, input bit hold);
    int cyc;
    for (int i = 0; i < msg.size(); i++) begin
      applyStimulus(sel, msg[i], i == 0, i == msg.size() - 1, hold, cyc);
      checkOutput(sel == 0 ? "period8" : "period16", 32'(cyc), sel == 0 ? 32'd3 : 32'd9);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; valid8 = 1'b0; valid16 = 1'b0; data_s = '0; first_s = 1'b0; last_s = 1'b0;
    mode_s = 1'b0; res_ready = 1'b1;
    poly8 = 9'h107; init8 = 8'h00; poly16 = 17'h11021; init16 = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready", 32'(rdy8), 32'd1);
    checkOutput("rst_res_valid", 32'(rv8), 32'd0);
    checkOutput("rst_crc", 32'(crc8), 32'd0);
    checkOutput("rst_match", 32'(match8), 32'd0);
    checkOutput("rst_ready16", 32'(rdy16), 32'd1);

    $display("[TB] generate CRC-8 of 123456789");
    msg = base;
    pushExp(0, 16'h00F4, 1'b0);
    sendMsg(0, 1'b0);

    $display("[TB] check mode, good and bad residue");
    mode_s = 1'b1;
    msg = base; msg.push_back(8'hF4);
    pushExp(0, 16'h0000, 1'b1);
    sendMsg(0, 1'b0);
    msg = base; msg.push_back(8'hF5);
    pushExp(0, 16'h0007, 1'b0);
    sendMsg(0, 1'b0);
    mode_s = 1'b0;

    $display("[TB] CRC-16 with CHUNK=1");
    msg = base;
    pushExp(1, 16'h31C3, 1'b0);
    sendMsg(1, 1'b0);
    init16 = 16'hFFFF;
    pushExp(1, 16'h29B1, 1'b0);
    sendMsg(1, 1'b0);

    $display("[TB] single-word message with result backpressure");
    @(posedge clk); #1 res_ready = 1'b0;
    pushExp(0, 16'h0007, 1'b0);
    applyStimulus(0, 8'h01, 1'b1, 1'b1, 1'b0, cyc);
    checkOutput("single_latency", 32'(cyc), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_res_valid", 32'(rv8), 32'd1);
      checkOutput("hold_crc", 32'(crc8), 32'h07);
      checkOutput("hold_ready", 32'(rdy8), 32'd0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("accept_ready", 32'(rdy8), 32'd1);
    checkOutput("accept_res_valid", 32'(rv8), 32'd0);

    $display("[TB] abort and restart, valid held during SHIFT");
    applyStimulus(0, 8'h31, 1'b1, 1'b0, 1'b0, cyc);
    applyStimulus(0, 8'h32, 1'b0, 1'b0, 1'b0, cyc);
    msg = base;
    pushExp(0, 16'h00F4, 1'b0);
    sendMsg(0, 1'b1);

    $display("[TB] reset during SHIFT");
    for (int i = 0; i < 4; i++) applyStimulus(0, base[i], i == 0, 1'b0, 1'b0, cyc);
    handshake(0, 8'h35, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(rdy8), 32'd1);
    checkOutput("midrst_res_valid", 32'(rv8), 32'd0);
    checkOutput("midrst_crc", 32'(crc8), 32'd0);
    msg = base;
    pushExp(0, 16'h00F4, 1'b0);
    sendMsg(0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("leftover8", 32'(q8.size()), 32'd0);
    checkOutput("leftover16", 32'(q16.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
